// File: rtl/random_clk_ctrl_pkg.sv
// Shared definitions for the random clock-enable controller.
//   state_e      : FSM encoding (IDLE / RUN / DONE)
//   LFSR_TAPS    : feedback tap mask of the 8-bit Fibonacci LFSR
//   BW_CNT_DEF   : default width of the pulse counter
//   lfsr8_next() : one LFSR step
package random_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Taps on bits 7,5,4,3 -> maximal length (255) sequence.
  localparam logic [7:0] LFSR_TAPS  = 8'hB8;
  localparam int         BW_CNT_DEF = 16;

  function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rclk_lfsr8.sv
// 8-bit Fibonacci LFSR holding register.
//   i_clk   : clock, rising edge
//   i_rstn  : synchronous active-low reset, loads SEED
//   i_load  : load i_val (wins over i_step)
//   i_val   : load value
//   i_step  : advance one step
//   o_q     : current state
module rclk_lfsr8
  import random_clk_ctrl_pkg::*;
#(
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_load,
  input  logic [7:0] i_val,
  input  logic       i_step,
  output logic [7:0] o_q
);

  logic [7:0] q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn)     q <= SEED;
    else if (i_load) q <= i_val;
    else if (i_step) q <= lfsr8_next(q);
  end

  assign o_q = q;

endmodule

// File: rtl/random_clk_ctrl.sv
// Random clock-enable controller: after a start it emits i_num enable
// pulses, each cycle pulsing when the LFSR value is below the captured
// threshold. i_stop aborts a run without a done pulse.
//   i_clk, i_rstn      : clock / synchronous active-low reset
//   i_start            : start request (IDLE only)
//   i_stop             : abort request (RUN only)
//   i_seed/i_thresh/i_num : run parameters captured on accepted start
//   o_clk_en           : random enable pulse
//   o_busy / o_done    : running / one-cycle completion
//   o_lfsr / o_cnt     : LFSR state / pulses emitted since start
module random_clk_ctrl
  import random_clk_ctrl_pkg::*;
#(
  parameter logic [7:0] SEED   = 8'h01,
  parameter int         BW_CNT = BW_CNT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [7:0]        i_seed,
  input  logic [7:0]        i_thresh,
  input  logic [BW_CNT-1:0] i_num,
  output logic              o_clk_en,
  output logic              o_busy,
  output logic              o_done,
  output logic [7:0]        o_lfsr,
  output logic [BW_CNT-1:0] o_cnt
);

  state_e            state_q, state_d;
  logic [7:0]        thresh_q;
  logic [BW_CNT-1:0] num_q;
  logic [BW_CNT-1:0] cnt;
  logic [7:0]        lfsr;
  logic              accept;
  logic              clk_en;
  logic              last;
  logic [7:0]        seed_fix;

  assign accept   = (state_q == IDLE) && i_start;
  // An all-zero seed would lock the LFSR up.
  assign seed_fix = (i_seed == 8'h00) ? 8'h01 : i_seed;
  assign clk_en   = (state_q == RUN) && (lfsr < thresh_q) && !i_stop;
  assign last     = (cnt == num_q - BW_CNT'(1));

  rclk_lfsr8 #(.SEED(SEED)) u_lfsr (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_load (accept),
    .i_val  (seed_fix),
    .i_step (state_q == RUN),
    .o_q    (lfsr)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q  <= IDLE;
      thresh_q <= '0;
      num_q    <= '0;
      cnt      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        thresh_q <= i_thresh;
        num_q    <= i_num;
        cnt      <= '0;
      end else if (clk_en) begin
        cnt <= cnt + BW_CNT'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_start) state_d = (i_num == '0) ? DONE : RUN;
      // Stop wins over completion and skips DONE.
      RUN:  if (i_stop) state_d = IDLE;
            else if (clk_en && last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_clk_en = clk_en;
  assign o_busy   = (state_q == RUN);
  assign o_done   = (state_q == DONE);
  assign o_lfsr   = lfsr;
  assign o_cnt    = cnt;

endmodule

// File: tb/tb_random_clk_ctrl.sv
module tb_random_clk_ctrl;

  localparam int BW = 16;

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b0;
  logic          i_start = 1'b0;
  logic          i_stop = 1'b0;
  logic [7:0]    i_seed = 8'h00;
  logic [7:0]    i_thresh = 8'h00;
  logic [BW-1:0] i_num = '0;
  logic          o_clk_en, o_busy, o_done;
  logic [7:0]    o_lfsr;
  logic [BW-1:0] o_cnt;

  random_clk_ctrl #(.SEED(8'h01), .BW_CNT(BW)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_stop(i_stop),
    .i_seed(i_seed), .i_thresh(i_thresh), .i_num(i_num),
    .o_clk_en(o_clk_en), .o_busy(o_busy), .o_done(o_done),
    .o_lfsr(o_lfsr), .o_cnt(o_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // ---------------- model ----------------
  // The LFSR is modelled as a position in the precomputed 255-entry orbit.
  logic [7:0] seq [255];
  int  m_ph  = 0;     // 0 idle, 1 run, 2 done
  int  m_pos = 0;
  int  m_cnt = 0;
  int  m_thr = 0;
  int  m_num = 0;
  bit  m_ok  = 0;
  int  en_seen = 0;
  int  done_seen = 0;

  function automatic int idx_of(input logic [7:0] v);
    for (int k = 0; k < 255; k++) if (seq[k] == v) return k;
    return 0;
  endfunction

  always @(posedge i_clk) begin
    bit en;
    if (!i_rstn) begin
      m_ph = 0; m_pos = idx_of(8'h01); m_cnt = 0; m_thr = 0; m_num = 0; m_ok = 1;
    end else if (m_ph == 0) begin
      if (i_start) begin
        m_pos = idx_of(i_seed == 0 ? 8'h01 : i_seed);
        m_thr = i_thresh; m_num = i_num; m_cnt = 0;
        m_ph  = (i_num == 0) ? 2 : 1;
      end
    end else if (m_ph == 1) begin
      en = (int'(seq[m_pos]) < m_thr) && !i_stop;
      if (en) m_cnt++;
      if (i_stop) m_ph = 0;
      else if (en && m_cnt == m_num) m_ph = 2;
      m_pos = (m_pos + 1) % 255;
    end else begin
      m_ph = 0;
    end
  end

  always @(negedge i_clk) begin
    if (m_ok) begin
      chk("clk_en", o_clk_en, (m_ph == 1) && (int'(seq[m_pos]) < m_thr) && !i_stop);
      chk("busy",   o_busy, m_ph == 1);
      chk("done",   o_done, m_ph == 2);
      chk("lfsr",   o_lfsr, seq[m_pos]);
      chk("cnt",    o_cnt,  m_cnt);
    end
    if (o_clk_en) en_seen++;
    if (o_done) done_seen++;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic start(input logic [7:0] s, input logic [7:0] t, input int n);
    i_seed = s; i_thresh = t; i_num = BW'(n); i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    en_seen = 0; done_seen = 0;
  endtask

  initial begin
    logic [7:0] v;
    v = 8'h01;
    for (int k = 0; k < 255; k++) begin
      seq[k] = v;
      v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    end

    // reset
    cyc(3);
    @(negedge i_clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_lfsr", o_lfsr, 8'h01);
    chk("rst_cnt",  o_cnt, 0);
    chk("rst_en",   o_clk_en, 0);
    i_rstn = 1'b1;
    cyc();

    // three pulses from seed 01
    start(8'h01, 8'h10, 3);
    @(negedge i_clk); chk("s1_lfsr1", o_lfsr, 8'h01); chk("s1_en1", o_clk_en, 1);
    cyc(); @(negedge i_clk); chk("s1_lfsr2", o_lfsr, 8'h02);
    cyc(); @(negedge i_clk); chk("s1_lfsr3", o_lfsr, 8'h04);
    cyc(); @(negedge i_clk); chk("s1_done", o_done, 1); chk("s1_cnt", o_cnt, 3);
    cyc(2);

    // full orbit, then stop
    start(8'h01, 8'h80, 200);
    cyc(255);
    @(negedge i_clk); chk("s2_lfsr", o_lfsr, 8'h01); chk("s2_cnt", o_cnt, 127);
    i_stop = 1'b1; cyc(); i_stop = 1'b0;
    @(negedge i_clk); chk("s2_busy", o_busy, 0);
    cyc(2);
    chk("s2_nodone", done_seen, 0);

    // zero seed
    start(8'h00, 8'h10, 1);
    @(negedge i_clk); chk("s3_lfsr", o_lfsr, 8'h01); chk("s3_en", o_clk_en, 1);
    cyc(); @(negedge i_clk); chk("s3_done", o_done, 1); chk("s3_cnt", o_cnt, 1);
    cyc(2);

    // num == 0
    start(8'h05, 8'hFF, 0);
    @(negedge i_clk); chk("s4_done", o_done, 1); chk("s4_busy", o_busy, 0);
    cyc(); @(negedge i_clk); chk("s4_done_off", o_done, 0);
    chk("s4_noen", en_seen, 0); chk("s4_cnt", o_cnt, 0);
    cyc();

    // thresh == 0 never pulses
    start(8'h37, 8'h00, 5);
    cyc(300);
    chk("s5_noen", en_seen, 0); chk("s5_busy", o_busy, 1);
    i_stop = 1'b1; cyc(); i_stop = 1'b0;
    cyc(2);
    chk("s5_idle", o_busy, 0); chk("s5_cnt", o_cnt, 0); chk("s5_nodone", done_seen, 0);

    // thresh == FF: FF is the only value that does not pulse; start ignored in RUN
    start(8'hFF, 8'hFF, 3);
    @(negedge i_clk); chk("s6_en_ff", o_clk_en, 0);
    i_start = 1'b1; i_num = BW'(1);
    cyc(); i_start = 1'b0;
    @(negedge i_clk); chk("s6_lfsr", o_lfsr, 8'hFE); chk("s6_en_fe", o_clk_en, 1);
    cyc(5);

    // reset mid-run, start during reset ignored
    start(8'h01, 8'h10, 10);
    cyc(2);
    @(negedge i_clk); chk("s7_cnt2", o_cnt, 2);
    i_rstn = 1'b0; i_start = 1'b1;
    cyc();
    @(negedge i_clk);
    chk("s7_busy", o_busy, 0); chk("s7_lfsr", o_lfsr, 8'h01); chk("s7_cnt", o_cnt, 0);
    i_rstn = 1'b1; i_start = 1'b0;
    cyc(2);
    @(negedge i_clk); chk("s7_idle", o_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
